// File: rtl/ifetch_unit.sv
// Instruction fetch controller: owns the PC and runs the single-outstanding bus handshake.
// Optional IFETCH_MISALIGN_CHECK_EN: misaligned fetch PCs yield a NOP plus fetch_misalign.
module ifetch_unit #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               fetch_en,
  input  logic               stall_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               ireq_valid,
  output logic [ADDR_W-1:0]  ireq_addr,
  input  logic               iresp_addr_ok,
  input  logic               iresp_data_ok,
  input  logic [INSTR_W-1:0] iresp_data,
  output logic               i_data_ok,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic               fetch_misalign
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  ireq_addr_q, ireq_addr_d;
  logic [INSTR_W-1:0] buf_q, buf_d;
  logic               discard_q, discard_d;
  logic               bypass;
  logic               next_fetch;

`ifdef IFETCH_MISALIGN_CHECK_EN
  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(32'h0000_0013);
  logic misalign_q, misalign_d;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      ireq_addr_q <= RESET_PC;
      buf_q       <= '0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ireq_addr_q <= ireq_addr_d;
      buf_q       <= buf_d;
      discard_q   <= discard_d;
    end
  end

`ifdef IFETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign fetch_misalign = misalign_q && (state_q == StHold) && !redirect_valid;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ireq_addr_d = ireq_addr_q;
    buf_d       = buf_q;
    discard_d   = discard_q;
    i_data_ok   = 1'b0;
    bypass      = 1'b0;
    next_fetch  = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif

    if (redirect_valid) pc_d = redirect_pc;

    unique case (state_q)
      StIdle: next_fetch = 1'b1;

      StReq, StWait: begin
        if ((state_q == StReq) && !iresp_addr_ok) begin
          // The bus forbids retracting a request, so a redirect only marks it stale.
          if (redirect_valid) discard_d = 1'b1;
        end else if (!iresp_data_ok) begin
          state_d = StWait;
          if (redirect_valid) discard_d = 1'b1;
        end else if (discard_q || redirect_valid) begin
          discard_d  = 1'b0;
          next_fetch = 1'b1;
        end else begin
          i_data_ok = 1'b1;
          bypass    = 1'b1;
          buf_d     = iresp_data;
          if (stall_pc) begin
            state_d = StHold;
          end else begin
            pc_d       = pc_q + ADDR_W'(4);
            next_fetch = 1'b1;
          end
        end
      end

      StHold: begin
        if (redirect_valid) begin
          state_d = StIdle;
          buf_d   = '0;
        end else begin
          i_data_ok = 1'b1;
          if (!stall_pc) begin
            pc_d       = pc_q + ADDR_W'(4);
            next_fetch = 1'b1;
          end
        end
`ifdef IFETCH_MISALIGN_CHECK_EN
        if (redirect_valid || !stall_pc) misalign_d = 1'b0;
`endif
      end

      default: state_d = StIdle;
    endcase

    // Every new request starts from the post-update PC, so redirects take effect here.
    if (next_fetch) begin
      if (!fetch_en) begin
        state_d = StIdle;
      end else begin
`ifdef IFETCH_MISALIGN_CHECK_EN
        ireq_addr_d = pc_d;
        if (pc_d[1:0] != 2'b00) begin
          state_d    = StHold;
          buf_d      = NOP;
          misalign_d = 1'b1;
        end else begin
          state_d = StReq;
        end
`else
        state_d     = StReq;
        ireq_addr_d = pc_d;
`endif
      end
    end
  end

  assign ireq_valid = (state_q == StReq);
  assign ireq_addr  = ireq_addr_q;
  assign instr_pc   = ireq_addr_q;
  assign instr      = bypass ? iresp_data : buf_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a randomized bus/hazard run
// checked against an architectural PC-stream model.
module tb_ifetch_unit;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_en, stall_pc, redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok, iresp_data_ok;
  logic [31:0] iresp_data;
  logic        i_data_ok;
  logic [31:0] instr;
  logic [63:0] instr_pc, pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ifetch_unit #(
    .ADDR_W  (64),
    .INSTR_W (32),
    .RESET_PC(RST_PC)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .fetch_en      (fetch_en),
    .stall_pc      (stall_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_addr_ok (iresp_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .i_data_ok     (i_data_ok),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc            (pc)
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic drive(input logic fe, input logic st, input logic rv, input logic [63:0] rpc,
                       input logic aok, input logic dok, input logic [31:0] d);
    fetch_en       = fe;
    stall_pc       = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    iresp_addr_ok  = aok;
    iresp_data_ok  = dok;
    iresp_data     = d;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    fetch_en = 1'b0; stall_pc = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    fetch_en = 1'b1; stall_pc = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'hffff_ffff;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if ({ireq_valid, i_data_ok} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valids got %b want 00", {ireq_valid, i_data_ok}); end
    n_checks++; if (instr !== 32'h0) begin
      n_fail++; $display("FAIL reset_instr got %h want 0", instr); end
    n_checks++; if (instr_pc !== RST_PC) begin
      n_fail++; $display("FAIL reset_instr_pc got %h want %h", instr_pc, RST_PC); end
    n_checks++; if (pc !== RST_PC) begin
      n_fail++; $display("FAIL reset_pc got %h want %h", pc, RST_PC); end
    next_cycle();
    resetn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    n_checks++; if (ireq_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_fetch_en got ireq_valid=%b want 0", ireq_valid); end
  endtask

  task automatic test_basic_fetch();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    n_checks++; if (ireq_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle_valid got %b want 0", ireq_valid); end
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
      n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC + 64'(4 * k)) begin
        n_fail++; $display("FAIL basic_req%0d got valid=%b addr=%h want 1 %h", k, ireq_valid,
                           ireq_addr, RST_PC + 64'(4 * k)); end
      n_checks++; if (pc !== RST_PC + 64'(4 * k)) begin
        n_fail++; $display("FAIL basic_pc%0d got %h want %h", k, pc, RST_PC + 64'(4 * k)); end
      next_cycle();
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, mem_word(RST_PC + 64'(4 * k)));
      n_checks++; if (i_data_ok !== 1'b1 || instr_pc !== RST_PC + 64'(4 * k)
                      || instr !== mem_word(RST_PC + 64'(4 * k))) begin
        n_fail++; $display("FAIL basic_data%0d got ok=%b pc=%h instr=%h want 1 %h %h", k,
                           i_data_ok, instr_pc, instr, RST_PC + 64'(4 * k),
                           mem_word(RST_PC + 64'(4 * k))); end
    end
  endtask

  task automatic test_stall_hold();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive(1'b1, i < 3, 1'b0, '0, 1'b0, i == 0, (i == 0) ? 32'h0000_0093 : 32'hdead_beef);
      n_checks++; if (i_data_ok !== 1'b1 || instr !== 32'h0000_0093 || pc !== RST_PC) begin
        n_fail++; $display("FAIL stall_hold%0d got ok=%b instr=%h pc=%h want 1 00000093 %h", i,
                           i_data_ok, instr, pc, RST_PC); end
    end
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    n_checks++; if (pc !== RST_PC + 64'd4 || i_data_ok !== 1'b0) begin
      n_fail++; $display("FAIL stall_release got pc=%h ok=%b want %h 0", pc, i_data_ok,
                         RST_PC + 64'd4); end
    n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC + 64'd4) begin
      n_fail++; $display("FAIL stall_next_req got valid=%b addr=%h want 1 %h", ireq_valid,
                         ireq_addr, RST_PC + 64'd4); end
  endtask

  task automatic test_redirect_wait();
    logic [63:0] tgt;
    tgt = 64'h8000_0100;
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, tgt, 1'b0, 1'b0, '0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, mem_word(RST_PC));
    n_checks++; if (i_data_ok !== 1'b0 || pc !== tgt) begin
      n_fail++; $display("FAIL rwait_drop got ok=%b pc=%h want 0 %h", i_data_ok, pc, tgt); end
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== tgt) begin
      n_fail++; $display("FAIL rwait_req got valid=%b addr=%h want 1 %h", ireq_valid,
                         ireq_addr, tgt); end
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, mem_word(tgt));
    n_checks++; if (i_data_ok !== 1'b1 || instr_pc !== tgt || instr !== mem_word(tgt)) begin
      n_fail++; $display("FAIL rwait_data got ok=%b pc=%h instr=%h want 1 %h %h", i_data_ok,
                         instr_pc, instr, tgt, mem_word(tgt)); end
  endtask

  task automatic test_redirect_req();
    logic [63:0] tgt;
    tgt = 64'h8000_0200;
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, tgt, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, '0, i == 2, 1'b0, '0);
      end
      n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC) begin
        n_fail++; $display("FAIL rreq_hold%0d got valid=%b addr=%h want 1 %h", i, ireq_valid,
                           ireq_addr, RST_PC); end
    end
    n_checks++; if (pc !== tgt) begin
      n_fail++; $display("FAIL rreq_pc got %h want %h", pc, tgt); end
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, mem_word(RST_PC));
    n_checks++; if (i_data_ok !== 1'b0) begin
      n_fail++; $display("FAIL rreq_drop got ok=%b want 0", i_data_ok); end
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, mem_word(tgt));
    n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== tgt) begin
      n_fail++; $display("FAIL rreq_new_req got valid=%b addr=%h want 1 %h", ireq_valid,
                         ireq_addr, tgt); end
    n_checks++; if (i_data_ok !== 1'b1 || instr_pc !== tgt || instr !== mem_word(tgt)) begin
      n_fail++; $display("FAIL rreq_same_cycle got ok=%b pc=%h instr=%h want 1 %h %h",
                         i_data_ok, instr_pc, instr, tgt, mem_word(tgt)); end
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    n_checks++; if (pc !== tgt + 64'd4) begin
      n_fail++; $display("FAIL rreq_pc_next got %h want %h", pc, tgt + 64'd4); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 64'h8000_0300, 1'b1, 1'b0, '0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    n_checks++; if (pc !== 64'h8000_0300) begin
      n_fail++; $display("FAIL areset_pre_pc got %h want 80000300", pc); end
    #1 resetn = 1'b0;
    #1;
    n_checks++; if ({ireq_valid, i_data_ok} !== 2'b00 || instr !== 32'h0) begin
      n_fail++; $display("FAIL areset_outs got valid=%b ok=%b instr=%h want 0 0 0", ireq_valid,
                         i_data_ok, instr); end
    n_checks++; if (pc !== RST_PC || instr_pc !== RST_PC) begin
      n_fail++; $display("FAIL areset_pcs got pc=%h instr_pc=%h want %h", pc, instr_pc,
                         RST_PC); end
    next_cycle();
    resetn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 32'hcafe_f00d);
    n_checks++; if (i_data_ok !== 1'b0) begin
      n_fail++; $display("FAIL areset_late_data got ok=%b want 0", i_data_ok); end
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    n_checks++; if (ireq_valid !== 1'b0 || pc !== RST_PC) begin
      n_fail++; $display("FAIL areset_idle got valid=%b pc=%h want 0 %h", ireq_valid, pc,
                         RST_PC); end
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, mem_word(RST_PC));
    n_checks++; if (i_data_ok !== 1'b1 || instr !== mem_word(RST_PC)) begin
      n_fail++; $display("FAIL areset_refetch got ok=%b instr=%h want 1 %h", i_data_ok, instr,
                         mem_word(RST_PC)); end
  endtask

  // Architectural model: the delivered stream is the sequential PC walk, restarted by redirects.
  task automatic test_random();
    logic [63:0] model_pc, pend_addr, prev_addr, rpc;
    logic        pend, prev_valid, prev_aok, prev_hold, fe, st, rv, aok, dok;
    logic [31:0] d;
    int          pend_lat, idle_cnt, deliveries, lat;
    apply_reset();
    model_pc = RST_PC; pend_addr = '0; prev_addr = '0;
    pend = 1'b0; prev_valid = 1'b0; prev_aok = 1'b0; prev_hold = 1'b0;
    pend_lat = 0; idle_cnt = 0; deliveries = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      fe  = ($urandom_range(9) < 8);
      st  = ($urandom_range(9) < 3);
      rv  = ($urandom_range(99) < 5);
      rpc = {32'h0, 32'h8000_0000 | ($urandom & 32'h000f_fffc)};
      if ($urandom_range(7) == 0) rpc = 64'hffff_ffff_ffff_fff0;
      aok = 1'b0; dok = 1'b0; d = '0;
      if (pend) begin
        if (pend_lat == 0) begin
          dok = 1'b1; d = mem_word(pend_addr); pend = 1'b0;
        end else begin
          pend_lat--;
        end
      end else if (ireq_valid && $urandom_range(9) < 6) begin
        aok = 1'b1;
        lat = $urandom_range(2);
        if (lat == 0) begin
          dok = 1'b1; d = mem_word(ireq_addr);
        end else begin
          pend = 1'b1; pend_addr = ireq_addr; pend_lat = lat - 1;
        end
      end
      drive(fe, st, rv, rpc, aok, dok, d);

      n_checks++; if (pc !== model_pc) begin
        n_fail++; $display("FAIL rand_pc cyc %0d got %h want %h", cyc, pc, model_pc); end
      if (prev_valid && !prev_aok) begin
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== prev_addr) begin
          n_fail++; $display("FAIL rand_req_stable cyc %0d got valid=%b addr=%h want 1 %h",
                             cyc, ireq_valid, ireq_addr, prev_addr); end
      end else if (ireq_valid) begin
        n_checks++; if (ireq_addr !== model_pc) begin
          n_fail++; $display("FAIL rand_req_addr cyc %0d got %h want %h", cyc, ireq_addr,
                             model_pc); end
      end
      if (rv) begin
        n_checks++; if (i_data_ok !== 1'b0) begin
          n_fail++; $display("FAIL rand_redirect_drop cyc %0d got ok=%b want 0", cyc,
                             i_data_ok); end
      end else if (prev_hold) begin
        n_checks++; if (i_data_ok !== 1'b1) begin
          n_fail++; $display("FAIL rand_hold cyc %0d got ok=%b want 1", cyc, i_data_ok); end
      end
      if (i_data_ok) begin
        n_checks++; if (instr_pc !== model_pc || instr !== mem_word(model_pc)) begin
          n_fail++; $display("FAIL rand_deliver cyc %0d got pc=%h instr=%h want %h %h", cyc,
                             instr_pc, instr, model_pc, mem_word(model_pc)); end
        deliveries++;
        idle_cnt = 0;
      end else begin
        idle_cnt++;
        if (idle_cnt > 64) begin
          n_checks++; n_fail++;
          $display("FAIL rand_liveness cyc %0d got no i_data_ok for %0d cycles want <=64",
                   cyc, idle_cnt);
          idle_cnt = 0;
        end
      end

      prev_hold  = i_data_ok && st && !rv;
      prev_valid = ireq_valid;
      prev_aok   = aok;
      prev_addr  = ireq_addr;
      if (rv) model_pc = rpc;
      else if (i_data_ok && !st) model_pc = model_pc + 64'd4;
      next_cycle();
    end
    n_checks++; if (deliveries < 200) begin
      n_fail++; $display("FAIL rand_throughput got %0d deliveries want >=200", deliveries); end
  endtask

`ifdef IFETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    apply_reset();
    drive(1'b1, 1'b1, 1'b1, 64'h8000_0102, 1'b0, 1'b0, '0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 32'hdead_beef);
    n_checks++; if (ireq_valid !== 1'b0 || fetch_misalign !== 1'b1) begin
      n_fail++; $display("FAIL misalign_flag got valid=%b mis=%b want 0 1", ireq_valid,
                         fetch_misalign); end
    n_checks++; if (i_data_ok !== 1'b1 || instr !== 32'h0000_0013) begin
      n_fail++; $display("FAIL misalign_nop got ok=%b instr=%h want 1 00000013", i_data_ok,
                         instr); end
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, RST_PC, 1'b0, 1'b0, '0);
    n_checks++; if (i_data_ok !== 1'b0 || fetch_misalign !== 1'b0) begin
      n_fail++; $display("FAIL misalign_redirect got ok=%b mis=%b want 0 0", i_data_ok,
                         fetch_misalign); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_req();
    test_async_reset();
    test_random();
`ifdef IFETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Front-end fetch controller that owns the PC and drives the instruction bus request/response handshake.
- Produces i_data_ok and the fetched instruction to the hazard unit and the F/D register.
- Consumes fetch_en and the PC stall from the hazard unit, plus branch/jump redirects from decode.
- Sits between the PC and the F/D pipeline register; at most one bus transaction is outstanding.

Parameters:
- RESET_PC, 64'h8000_0000, PC value after reset.
- ADDR_W, 64, PC and bus address width.
- INSTR_W, 32, instruction width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- fetch_en  in  1  hazard permits a new bus request.
- stall_pc  in  1  hazard PC stall (regstall_en.pc).
- redirect_valid  in  1  one-cycle redirect request (mispredict or jump).
- redirect_pc  in  ADDR_W  redirect target.
- ireq_valid  out  1  instruction bus request valid.
- ireq_addr  out  ADDR_W  request address.
- iresp_addr_ok  in  1  bus accepted the address.
- iresp_data_ok  in  1  read data valid.
- iresp_data  in  INSTR_W  read data.
- i_data_ok  out  1  instr/instr_pc valid this cycle.
- instr  out  INSTR_W  fetched instruction.
- instr_pc  out  ADDR_W  PC of instr.
- pc  out  ADDR_W  current fetch PC.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - Reset is asynchronous and active-low on resetn.
  - Reset values: state=IDLE, pc=RESET_PC, buf=0, discard=0.
  - Output reset values: ireq_valid=0, i_data_ok=0, instr=0, instr_pc=RESET_PC.
- States: IDLE, REQ, WAIT, HOLD.
- Outputs:
  - ireq_valid = (state==REQ).
  - ireq_addr is registered, captured from pc on entry to REQ, and held stable until addr_ok.
- IDLE: if fetch_en, go to REQ next cycle and latch ireq_addr=pc.
- REQ:
  - Hold valid and addr until iresp_addr_ok.
  - On addr_ok without data_ok, go to WAIT.
  - On addr_ok and data_ok in the same cycle, handle as the WAIT data_ok case in that cycle.
- WAIT, on data_ok:
  - If discard: drop the data, clear discard, i_data_ok=0; go to REQ if fetch_en, else IDLE.
  - Else: i_data_ok=1 combinationally that cycle; instr=iresp_data (bypass); instr_pc=ireq_addr; buf<=iresp_data.
  - Then, if stall_pc, go to HOLD.
  - Else pc<=pc+4; go to REQ (address pc+4) if fetch_en, else IDLE.
- HOLD:
  - i_data_ok=1, instr=buf, held stable.
  - When stall_pc=0: pc<=pc+4, then REQ/IDLE per fetch_en.
- i_data_ok is 0 in IDLE, REQ, and WAIT without data_ok; the hazard unit stalls the front end on this.
- Redirect (highest priority, any state):
  - pc<=redirect_pc.
  - In REQ: keep ireq_valid and the old address until addr_ok (the bus rule forbids retracting), and set discard.
  - In WAIT without data_ok: set discard.
  - In WAIT with data_ok the same cycle: the data is dropped, i_data_ok=0, no discard; go to REQ/IDLE per fetch_en.
  - In HOLD: drop buf, i_data_ok=0, go to IDLE.
  - The next request always uses redirect_pc.
  - A second redirect while discard is set only updates pc.
- pc+4 wraps modulo 2^ADDR_W.
- stall_pc without i_data_ok has no effect on pc.

Optional Feature:
- Macro: IFETCH_MISALIGN_CHECK_EN.
- With the macro defined:
  - Adds output fetch_misalign (1 bit).
  - When pc[1:0]!=0 at the point a request would be issued, no bus request is made.
  - The unit enters HOLD with instr=32'h0000_0013 (NOP), i_data_ok=1 and fetch_misalign=1.
  - These hold until a redirect or until the stall releases.
- Without the macro: no port, no check; the low address bits are passed through unchanged.

Test Plan:
- Reset release with fetch_en=1 and a bus with 1-cycle addr_ok and 1-cycle data_ok -> ireq_addr=8000_0000, then 8000_0004; i_data_ok pulses with instr_pc matching each address.
- data_ok with stall_pc=1 for 3 cycles, data=0000_0093 -> i_data_ok=1 and instr=0000_0093 for 4 cycles, pc held; pc=+4 after release.
- redirect_valid to 8000_0100 while in WAIT -> the following data_ok is dropped (i_data_ok=0), and the next ireq_addr=8000_0100.
- redirect while in REQ with addr_ok delayed 2 cycles -> ireq_addr stays at the old address until addr_ok, its data is discarded, then a request to the target is issued.
- resetn asserted low mid-WAIT -> outputs return to reset values immediately (asynchronously); a late data_ok after release is ignored in IDLE.
- With IFETCH_MISALIGN_CHECK_EN, redirect to 8000_0102 -> no ireq_valid, fetch_misalign=1, instr=0000_0013.
